// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding,
// default datapath width and counter sizing.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Bit counter width for a given operand width (WIDTH >= 2 keeps this >= 1).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational full subtractor built from two 4:1 muxes selected by {bin,b}.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic [1:0] sel;
  logic       a_n;

  assign sel = {bin, b};
  assign a_n = ~a;

  mux4x1 u_mux_d (
    .sel (sel),
    .i0  (a),
    .i1  (a_n),
    .i2  (a_n),
    .i3  (a),
    .y   (d)
  );

  // Borrow is generated only when the subtracted amount (b + bin) exceeds a.
  mux4x1 u_mux_bout (
    .sel (sel),
    .i0  (1'b0),
    .i1  (a_n),
    .i2  (a_n),
    .i3  (1'b1),
    .y   (bout)
  );

endmodule

// File: rtl/mux4x1.sv
// Single-bit 4:1 multiplexer, select {s1,s0} picks i0..i3.
module mux4x1 (
  input  logic [1:0] sel,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  output logic       y
);

  assign y = sel[1] ? (sel[0] ? i3 : i2) : (sel[0] ? i1 : i0);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// behind a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one operand bit processed per clock, WIDTH clocks total
// DONE  | one-cycle result strobe; start here begins the next operation
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] work;
  logic             br;
  logic             cell_d;
  logic             cell_nb;
  logic [WIDTH-1:0] work_next;

  full_sub_cell u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_nb)
  );

  // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign work_next = {cell_d, work[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
      work  <= '0;
      br    <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            work  <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          work <= work_next;
          br   <= cell_nb;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            diff  <= work_next;
            bout  <= cell_nb;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: stimulus pushes expected results into
// a scoreboard queue, a monitor pops and compares on every done strobe.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
  } result_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  logic c_a = 1'b0, c_b = 1'b0, c_bin = 1'b0;
  logic c_d, c_bout;

  int checks = 0;
  int failures = 0;
  result_t sb_q[$];
  logic [W-1:0] exp_prev = '0;
  bit clr_window = 1'b1;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  full_sub_cell u_cell (
    .a    (c_a),
    .b    (c_b),
    .bin  (c_bin),
    .d    (c_d),
    .bout (c_bout)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares on done, and flags any output change outside done/reset.
  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;
  always @(negedge clk) begin
    if (busy && done) chk("busy_done_overlap", 1, 0);
    if (done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        result_t e;
        e = sb_q.pop_front();
        chk("sb_diff", int'(diff), int'(e.diff));
        chk("sb_bout", int'(bout), int'(e.bout));
      end
      last_diff = diff;
      last_bout = bout;
    end else if (clr_window || rst) begin
      last_diff = diff;
      last_bout = bout;
    end else if (diff != last_diff || bout != last_bout) begin
      chk("output_hold", int'({diff, bout}), int'({last_diff, last_bout}));
      last_diff = diff;
      last_bout = bout;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One operation. junk_cyc: cycle to pulse start with other operands while
  // busy. rst_cyc: cycle to assert reset mid-operation (no result expected).
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, input logic [W-1:0] ed, input logic eb,
                        input int junk_cyc, input int rst_cyc);
    int cyc = 0;
    int busy_cnt = 0;
    bit got = 0;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    if (rst_cyc == 0) sb_q.push_back('{diff: ed, bout: eb});
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (cyc == 1) begin a = ~ta; b = ~tb_v; bin = ~tbin; end
      if (cyc == junk_cyc) begin
        chk({name, "_diff_held"}, int'(diff), int'(exp_prev));
        start = 1'b1; a = 8'd1; b = 8'd1; bin = 1'b1;
      end
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        clr_window = 1'b1;
        @(negedge clk);
        chk({name, "_rst_busy"}, int'(busy), 0);
        chk({name, "_rst_done"}, int'(done), 0);
        chk({name, "_rst_diff"}, int'(diff), 0);
        chk({name, "_rst_bout"}, int'(bout), 0);
        rst = 1'b0;
        exp_prev = '0;
        @(negedge clk);
        clr_window = 1'b0;
        idle(15);
        return;
      end
      if (done) got = 1;
    end
    chk({name, "_done_seen"}, int'(got), 1);
    chk({name, "_latency"}, cyc, W + 1);
    chk({name, "_busy_cycles"}, busy_cnt, W);
    exp_prev = ed;
    idle(junk_cyc != 0 ? 12 : 2);
  endtask

  initial begin
    logic [7:0] bout_mask;
    bout_mask = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {c_a, c_b, c_bin} = v;
      #1;
      chk($sformatf("cell_d_%0d", i), int'(c_d), int'(^v));
      chk($sformatf("cell_bout_%0d", i), int'(c_bout), int'(bout_mask[i]));
    end

    idle(2);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_diff", int'(diff), 0);
    chk("reset_bout", int'(bout), 0);
    rst = 1'b0;
    @(negedge clk);
    clr_window = 1'b0;

    run_op("op_100_37", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 0, 0);
    run_op("op_5_10", 8'd5, 8'd10, 1'b0, 8'd251, 1'b1, 0, 0);
    run_op("op_0_0_1", 8'd0, 8'd0, 1'b1, 8'd255, 1'b1, 0, 0);
    run_op("op_255_255", 8'd255, 8'd255, 1'b0, 8'd0, 1'b0, 0, 0);
    run_op("op_0_255_1", 8'd0, 8'd255, 1'b1, 8'd0, 1'b1, 0, 0);
    run_op("op_255_0_1", 8'd255, 8'd0, 1'b1, 8'd254, 1'b0, 0, 0);
    run_op("op_ignore", 8'd90, 8'd17, 1'b1, 8'd72, 1'b0, 3, 0);
    run_op("op_reset", 8'd50, 8'd20, 1'b0, 8'd0, 1'b0, 0, 4);
    run_op("op_after_rst", 8'd12, 8'd34, 1'b0, 8'd234, 1'b1, 0, 0);

    // Back-to-back: start held through the DONE cycle.
    begin
      int cyc = 0;
      bit got = 0;
      a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
      sb_q.push_back('{diff: 8'd63, bout: 1'b0});
      while (!got && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (done) got = 1;
      end
      chk("b2b_first_done", int'(got), 1);
      a = 8'd200; b = 8'd1; bin = 1'b0;
      sb_q.push_back('{diff: 8'd199, bout: 1'b0});
      cyc = 0;
      got = 0;
      while (!got && cyc < 40) begin
        @(negedge clk);
        cyc++;
        start = 1'b0;
        if (done) got = 1;
      end
      chk("b2b_second_done", int'(got), 1);
      chk("b2b_spacing", cyc, W + 1);
      idle(3);
    end

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
